// File: rtl/seq_alu.sv
// seq_alu: multi-cycle ALU with valid/ready handshakes and iterative signed/unsigned multiply and divide
//   clk                   rising-edge clock
//   rst_n                 asynchronous active-low reset
//   in_valid, in_ready    request handshake; x, y, sel are sampled only on the accept edge
//   x, y, sel             operands and operation select
//   out_valid, out_ready  result handshake; outputs are held while out_valid=1 until out_ready=1
//   result, result2       primary result; high product or remainder (else 0)
//   OF, CF, DZ            signed overflow, carry/no-borrow, divide-by-zero
module seq_alu #(
  parameter int WIDTH = 32,
  localparam int SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [3:0]       sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result2,
  output logic             OF,
  output logic             CF,
  output logic             DZ
);
  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
  localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};
  state_t state_q, state_d;
  logic [WIDTH-1:0] x_q, x_d, y_q, y_d, hi_q, hi_d, lo_q, lo_d, res_q, res_d, res2_q, res2_d;
  logic [3:0] sel_q, sel_d;
  logic [SHW-1:0] cnt_q, cnt_d;
  logic rdy_q, of_q, of_d, cf_q, cf_d, dz_q, dz_d;
  logic [WIDTH-1:0] a_r, a_r2, ax_in, ay, quo, rem;
  logic a_of, a_cf, a_dz, dge, pneg, qneg, rneg;
  logic [WIDTH:0] add_s, sub_s, msum, dsh;
  logic [2*WIDTH-1:0] mprod;
  assign in_ready  = rdy_q;
  assign out_valid = state_q == DONE;
  assign result    = res_q;
  assign result2   = res2_q;
  assign OF        = of_q;
  assign CF        = cf_q;
  assign DZ        = dz_q;
  // iterative ops work on magnitudes; signs are restored from x_q/y_q at the end
  assign ax_in = (sel == 4'd13 || sel == 4'd14) && x[WIDTH-1] ? -x : x;
  assign ay    = (sel_q == 4'd13 || sel_q == 4'd14) && y_q[WIDTH-1] ? -y_q : y_q;
  assign add_s = {1'b0, x} + {1'b0, y};
  assign sub_s = {1'b0, x} + {1'b0, ~y} + {{WIDTH{1'b0}}, 1'b1};
  // shift-add step: hi_q accumulates, lo_q holds the unconsumed multiplier bits
  assign msum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, ay} : '0);
  assign mprod = {msum, lo_q[WIDTH-1:1]};
  assign pneg  = sel_q == 4'd13 && (x_q[WIDTH-1] ^ y_q[WIDTH-1]);
  // restoring step: hi_q is the partial remainder, lo_q shifts dividend bits out and quotient bits in
  assign dsh   = {hi_q, lo_q[WIDTH-1]};
  assign dge   = dsh >= {1'b0, ay};
  assign rem   = dge ? WIDTH'(dsh - {1'b0, ay}) : dsh[WIDTH-1:0];
  assign quo   = {lo_q[WIDTH-2:0], dge};
  assign qneg  = sel_q == 4'd14 && (x_q[WIDTH-1] ^ y_q[WIDTH-1]);
  assign rneg  = sel_q == 4'd14 && x_q[WIDTH-1];
  always_comb begin
    a_r  = '0;
    a_r2 = '0;
    a_of = 1'b0;
    a_cf = 1'b0;
    a_dz = 1'b0;
    case (sel)
      4'd0: a_r = x << y[SHW-1:0];
      4'd1: a_r = $signed(x) >>> y[SHW-1:0];
      4'd2: a_r = x >> y[SHW-1:0];
      4'd4, 4'd14: begin
        a_r  = '1;
        a_r2 = x;
        a_dz = 1'b1;
      end
      4'd5: begin
        a_r  = add_s[WIDTH-1:0];
        a_cf = add_s[WIDTH];
        a_of = x[WIDTH-1] == y[WIDTH-1] && add_s[WIDTH-1] != x[WIDTH-1];
      end
      4'd6: begin
        a_r  = sub_s[WIDTH-1:0];
        a_cf = sub_s[WIDTH];
        a_of = x[WIDTH-1] != y[WIDTH-1] && sub_s[WIDTH-1] != x[WIDTH-1];
      end
      4'd7:  a_r = x & y;
      4'd8:  a_r = x | y;
      4'd9:  a_r = x ^ y;
      4'd10: a_r = ~(x | y);
      4'd11: a_r = {{(WIDTH-1){1'b0}}, $signed(x) < $signed(y)};
      4'd12: a_r = {{(WIDTH-1){1'b0}}, x < y};
      default: ;
    endcase
  end
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    res_d   = res_q;
    res2_d  = res2_q;
    of_d    = of_q;
    cf_d    = cf_q;
    dz_d    = dz_q;
    case (state_q)
      IDLE: if (in_valid && rdy_q) begin
        x_d   = x;
        y_d   = y;
        sel_d = sel;
        hi_d  = '0;
        lo_d  = ax_in;
        cnt_d = SHW'(WIDTH-1);
        if (sel == 4'd3 || sel == 4'd13) state_d = MUL;
        else if ((sel == 4'd4 || sel == 4'd14) && y != '0) state_d = DIV;
        else begin
          state_d = DONE;
          res_d   = a_r;
          res2_d  = a_r2;
          of_d    = a_of;
          cf_d    = a_cf;
          dz_d    = a_dz;
        end
      end
      MUL: begin
        {hi_d, lo_d} = mprod;
        cnt_d = cnt_q - SHW'(1);
        if (cnt_q == '0) begin
          state_d         = DONE;
          {res2_d, res_d} = pneg ? -mprod : mprod;
          of_d            = 1'b0;
          cf_d            = 1'b0;
          dz_d            = 1'b0;
        end
      end
      DIV: begin
        hi_d  = rem;
        lo_d  = quo;
        cnt_d = cnt_q - SHW'(1);
        if (cnt_q == '0) begin
          state_d = DONE;
          res_d   = qneg ? -quo : quo;
          res2_d  = rneg ? -rem : rem;
          // MIN / -1 naturally yields quotient MIN, remainder 0; only the flag is extra
          of_d    = sel_q == 4'd14 && x_q == MIN && y_q == '1;
          cf_d    = 1'b0;
          dz_d    = 1'b0;
        end
      end
      default: if (out_ready) state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rdy_q   <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      sel_q   <= '0;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      res_q   <= '0;
      res2_q  <= '0;
      of_q    <= 1'b0;
      cf_q    <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      rdy_q   <= state_d == IDLE;
      x_q     <= x_d;
      y_q     <= y_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      res_q   <= res_d;
      res2_q  <= res2_d;
      of_q    <= of_d;
      cf_q    <= cf_d;
      dz_q    <= dz_d;
    end
  end
endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: randomized and directed check of seq_alu against an arithmetic reference model
module tb_seq_alu;
  localparam int W = 32;
  localparam int SH = $clog2(W);
  localparam longint LIM = longint'(1) << (W-1);
  localparam logic [W-1:0] MIN = {1'b1, {(W-1){1'b0}}};
  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [W-1:0] x = '0, y = '0;
  logic [3:0] sel = '0;
  logic in_ready, out_valid, OF, CF, DZ;
  logic [W-1:0] result, result2;
  int tests = 0, fails = 0;
  logic [W-1:0] e_r, e_r2;
  logic e_of, e_cf, e_dz;
  int e_lat;
  time t0;
  bit pend = 1'b0, seen = 1'b0;
  seq_alu #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y), .sel(sel), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .result2(result2), .OF(OF), .CF(CF), .DZ(DZ)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", n, act, exp, $time);
    end
  endtask
  function automatic void model(input logic [W-1:0] a, b, input logic [3:0] s,
                                output logic [W-1:0] r, r2, output logic of, cf, dz, output int lat);
    logic signed [2*W-1:0] sa, sb, p;
    sa = {{W{a[W-1]}}, a};
    sb = {{W{b[W-1]}}, b};
    r = '0; r2 = '0; of = 0; cf = 0; dz = 0; lat = 1;
    case (s)
      4'd0: r = a << b[SH-1:0];
      4'd1: begin p = sa >>> b[SH-1:0]; r = p[W-1:0]; end
      4'd2: r = a >> b[SH-1:0];
      4'd3, 4'd13: begin
        p = (s == 4'd3) ? {{W{1'b0}}, a} * {{W{1'b0}}, b} : sa * sb;
        r = p[W-1:0]; r2 = p[2*W-1:W]; lat = W + 1;
      end
      4'd4, 4'd14: begin
        if (b == '0) begin r = '1; r2 = a; dz = 1; end
        else begin
          lat = W + 1;
          if (s == 4'd4) begin r = a / b; r2 = a % b; end
          else begin
            p = sa / sb; r = p[W-1:0];
            p = sa % sb; r2 = p[W-1:0];
            of = (a == MIN) && (b == '1);
          end
        end
      end
      4'd5: begin r = a + b; cf = ({1'b0, a} + {1'b0, b}) > {1'b0, {W{1'b1}}}; p = sa + sb; of = p >= LIM || p < -LIM; end
      4'd6: begin r = a - b; cf = a >= b; p = sa - sb; of = p >= LIM || p < -LIM; end
      4'd7: r = a & b;
      4'd8: r = a | b;
      4'd9: r = a ^ b;
      4'd10: r = ~(a | b);
      4'd11: r = W'(sa < sb);
      4'd12: r = W'(a < b);
      default: ;
    endcase
  endfunction
  always @(negedge clk) if (rst_n && out_valid) begin
    if (!pend) chk("spurious_out_valid", out_valid, 0);
    else begin
      if (!seen) begin chk("latency", ($time - t0) / 10, e_lat); seen = 1'b1; end
      chk("result", result, e_r);
      chk("result2", result2, e_r2);
      chk("OF", OF, e_of);
      chk("CF", CF, e_cf);
      chk("DZ", DZ, e_dz);
      chk("in_ready_in_done", in_ready, 0);
    end
  end
  task automatic junk(input bit orr);
    in_valid  = 1'($urandom);
    x         = W'($urandom);
    y         = W'($urandom);
    sel       = 4'($urandom);
    out_ready = orr & 1'($urandom);
  endtask
  task automatic op(input logic [W-1:0] a, b, input logic [3:0] s, input int hold);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin @(negedge clk); n++; end
    if (!in_ready) begin chk("in_ready_timeout", in_ready, 1); return; end
    model(a, b, s, e_r, e_r2, e_of, e_cf, e_dz, e_lat);
    x = a; y = b; sel = s; in_valid = 1'b1; out_ready = 1'b0;
    t0 = $time; seen = 1'b0; pend = 1'b1;
    n = 0;
    do begin
      @(negedge clk); n++;
      if (!out_valid) junk(1);
    end while (!out_valid && n < W + 10);
    if (!out_valid) begin
      chk("out_valid_timeout", out_valid, 1);
      in_valid = 1'b0; out_ready = 1'b0; pend = 1'b0;
      return;
    end
    for (int i = 0; i < hold; i++) begin junk(0); @(negedge clk); end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    chk("out_valid_drop", out_valid, 0);
    chk("in_ready_back", in_ready, 1);
    pend = 1'b0; out_ready = 1'b0;
  endtask
  initial begin
    logic [W-1:0] r, r2, a, b;
    logic of, cf, dz;
    logic [3:0] s;
    int lat;
    model(32'h7FFFFFFF, 32'h1, 4'd5, r, r2, of, cf, dz, lat);
    chk("pin_add", {r, of, cf}, {32'h80000000, 1'b1, 1'b0});
    model(32'h0, 32'h1, 4'd6, r, r2, of, cf, dz, lat);
    chk("pin_sub", {r, of, cf}, {32'hFFFFFFFF, 1'b0, 1'b0});
    model(32'hFFFFFFFF, 32'hFFFFFFFF, 4'd3, r, r2, of, cf, dz, lat);
    chk("pin_mulu", {r, r2, 32'(lat)}, {32'h1, 32'hFFFFFFFE, 32'd33});
    model(32'hFFFFFFFF, 32'hFFFFFFFF, 4'd13, r, r2, of, cf, dz, lat);
    chk("pin_muls", {r, r2}, {32'h1, 32'h0});
    model(-32'sd7, 32'h2, 4'd14, r, r2, of, cf, dz, lat);
    chk("pin_divs", {r, r2}, {32'hFFFFFFFD, 32'hFFFFFFFF});
    model(32'h80000000, 32'hFFFFFFFF, 4'd14, r, r2, of, cf, dz, lat);
    chk("pin_divs_ovf", {r[31:0], r2[31:0]}, {32'h80000000, 32'h0});
    chk("pin_divs_ovf_flag", {of, 32'(lat)}, {1'b1, 32'd33});
    model(32'h1234, 32'h0, 4'd4, r, r2, of, cf, dz, lat);
    chk("pin_dz", {r, r2, dz, 32'(lat)}, {32'hFFFFFFFF, 32'h1234, 1'b1, 32'd1});
    #12;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_outputs", {result, result2, OF, CF, DZ}, '0);
    #8 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("in_ready_after_rst", in_ready, 1);
    op(32'h7FFFFFFF, 32'h1, 4'd5, 0);
    op(32'h0, 32'h1, 4'd6, 0);
    op(32'hFFFFFFFF, 32'hFFFFFFFF, 4'd3, 10);
    op(32'hFFFFFFFF, 32'hFFFFFFFF, 4'd13, 0);
    op(-32'sd7, 32'h2, 4'd14, 0);
    op(32'h80000000, 32'hFFFFFFFF, 4'd14, 0);
    op(32'h1234, 32'h0, 4'd4, 10);
    op(32'h5, 32'h0, 4'd14, 2);
    op(32'h12345678, 32'h9ABCDEF0, 4'd15, 0);
    @(negedge clk);
    x = 32'd100; y = 32'd7; sel = 4'd4; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0; pend = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 0);
    chk("midrst_result", {result, result2}, '0);
    @(posedge clk); #1;
    chk("midrst_hold", {out_valid, in_ready, result}, '0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("midrst_in_ready_release", in_ready, 1);
    chk("midrst_out_valid_release", out_valid, 0);
    repeat (W + 5) begin
      @(negedge clk);
      chk("midrst_no_completion", {out_valid, result}, '0);
    end
    for (int i = 0; i < 300; i++) begin
      s = 4'($urandom);
      a = W'($urandom);
      b = W'($urandom);
      case ($urandom_range(0, 7))
        0: b = '0;
        1: b = W'($urandom_range(0, 40));
        2: begin a = MIN; b = '1; end
        3: a = W'($urandom_range(0, 100)) - W'(50);
        4: b = W'($urandom_range(0, 20)) - W'(10);
        default: ;
      endcase
      op(a, b, s, $urandom_range(0, 3));
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Parametrised, multi-cycle successor of the combinational CPU ALU. Generalised to WIDTH bits.
- Adds a valid/ready handshake on input and output.
- Multiply and divide are iterative (one bit per cycle) and add signed variants. Divide-by-zero and signed-overflow are defined and flagged.
- Sits between the decode/issue stage and writeback of the single-cycle CPU's multi-cycle extension.

Parameters:
WIDTH, 32, operand/result width in bits (>=8, power of two)
SHW, $clog2(WIDTH), shift-amount width; derived, do not override

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operation request
in_ready  out  1  block can accept a request
x  in  WIDTH  operand X
y  in  WIDTH  operand Y
sel  in  4  operation select
out_valid  out  1  result/flags valid
out_ready  in  1  consumer accepts result
result  out  WIDTH  primary result
result2  out  WIDTH  high product / remainder, else 0
OF  out  1  signed overflow flag
CF  out  1  carry flag (add carry-out; sub carry-out of x+~y+1, 1 = no borrow)
DZ  out  1  divide-by-zero flag

Behaviour:
- Reset is asynchronous and active-low. While rst_n=0: state=IDLE, in_ready=0, out_valid=0, and result, result2, OF, CF, DZ, all datapath registers = 0.
- After reset release, in_ready=1 from the first clock edge.
- Reset asserted mid-operation aborts the operation. No result is produced; the block returns to IDLE.
- Opcodes:
  - 0 SHL; 1 SRA; 2 SRL. Shift amount = y[SHW-1:0].
  - 3 MULU: result=low, result2=high of the unsigned 2*WIDTH product.
  - 4 DIVU: result=quotient, result2=remainder.
  - 5 ADD; 6 SUB; 7 AND; 8 OR; 9 XOR; 10 NOR.
  - 11 SLT signed; 12 SLTU. Result = 0 or 1, zero-extended.
  - 13 MULS: signed product, low/high as for op 3.
  - 14 DIVS: signed, quotient truncated toward zero, remainder takes the dividend's sign.
  - 15: result=0, all flags 0.
- Flags:
  - OF and CF are nonzero only for ops 5 and 6. OF = carry into MSB XOR carry out of MSB.
  - DZ is nonzero only for ops 4 and 14.
  - All flags are 0 for every other op.
- States: IDLE, MUL, DIV, DONE.
  - IDLE: in_ready=1. On in_valid=1, latch x, y, sel.
    - Ops 3/13 go to MUL.
    - Ops 4/14 with y!=0 go to DIV.
    - All other ops, including divide-by-zero, compute combinationally from the latched operands and go directly to DONE.
  - MUL: shift-add on operand magnitudes, one bit per cycle, WIDTH cycles, counter WIDTH-1 down to 0. Then go to DONE. For op 13, the 2*WIDTH product is negated when the operand signs differ.
  - DIV: restoring division on magnitudes, one quotient bit per cycle, WIDTH cycles. Sign fix-up is applied on the transition to DONE.
  - DONE: in_ready=0, out_valid=1. result, result2 and flags are stable and held until out_ready=1. When out_ready=1, go to IDLE; out_valid drops on that edge.
- Latency, counted in edges from the accept edge to out_valid=1:
  - Single-step ops: 1 edge.
  - MUL/DIV: WIDTH+1 edges.
- There is no back-to-back acceptance. in_ready is high only in IDLE, so peak throughput for single-step ops is one operation per 2 cycles.
- Divide by zero (ops 4/14 with y=0):
  - result = all ones; result2 = x; DZ=1.
  - Latency 1 edge.
- Signed divide overflow (op 14, x = most-negative value, y = -1):
  - result = x; result2 = 0; OF=1.
  - Latency is WIDTH+1 edges, the same as any other divide.
- Inputs are sampled only on the accept edge. Changes to x, y, sel, or in_valid at any other time have no effect.
- out_ready while not in DONE is ignored.

Test Plan:
- Reset with rst_n=0 mid-DIV, then release → out_valid=0 and result=0 throughout; in_ready=1 on the first edge after release; no spurious completion.
- WIDTH=32, sel=5, x=0x7FFFFFFF, y=1 → out_valid 1 edge after accept, result=0x80000000, OF=1, CF=0. Then sel=6, x=0, y=1 → result=0xFFFFFFFF, CF=0, OF=0.
- sel=3, x=y=0xFFFFFFFF → out_valid exactly 33 edges after accept, result=0x00000001, result2=0xFFFFFFFE. Then sel=13 with the same operands → result=1, result2=0.
- sel=14, x=-7, y=2 → result=-3, result2=-1. Then x=0x80000000, y=0xFFFFFFFF → result=0x80000000, result2=0, OF=1, after 33 edges.
- sel=4, y=0, x=0x1234 → after 1 edge: result=0xFFFFFFFF, result2=0x1234, DZ=1.
- Backpressure: hold out_ready=0 for 10 cycles after completion and toggle x, y, sel, in_valid → outputs stable, in_ready=0. On out_ready=1, out_valid falls next edge and in_ready=1.
